// File: rtl/core_pkg.sv
// Shared core constants: datapath width, restart PC and the canonical NOP.
package core_pkg;
    localparam int          CORE_XLEN     = 32;
    localparam logic [31:0] CORE_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for fetched {pc, instr} entries; flush empties it in one edge.
module fetch_fifo #(
    parameter int             W         = 64,
    parameter int             DEPTH     = 2,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  logic [W-1:0]                   push_data,
    output logic [W-1:0]                   head,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;

    // Storage is reset too so the head shows RESET_VAL before the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-based issue to a 1-cycle imem, and wrong-path kill
// on redirect/pc_rst. Fetched words queue in fetch_fifo ahead of IF/ID.
module fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = CORE_XLEN,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(CORE_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_nxt,
    output logic [31:0]     out_instr
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int W  = XLEN + 32;

    logic            flush, deq, push, inflight_q;
    logic [XLEN-1:0] target, fetch_pc, inflight_pc_q;
    logic [CW-1:0]   count;
    logic [CW:0]     credit;
    logic [W-1:0]    head;

    assign flush     = pc_rst | redirect;
    assign target    = pc_rst ? RESET_PC : redirect_pc;
    assign imem_addr = flush ? target : fetch_pc;
    assign out_valid = (count != '0) & ~flush;
    assign deq       = out_valid & ~stall;

    // Buffered plus in-flight words must leave room for the next response.
    assign credit   = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(deq);
    assign imem_req = rst & (flush | (credit < (CW+1)'(DEPTH)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc      <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                fetch_pc      <= imem_addr + XLEN'(1);
                inflight_pc_q <= imem_addr;
            end
        end
    end

    // A response landing in a flush cycle belongs to the abandoned path.
    assign push = inflight_q & ~flush;

    fetch_fifo #(
        .W        (W),
        .DEPTH    (DEPTH),
        .RESET_VAL({RESET_PC, 32'h0})
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .push     (push),
        .pop      (deq),
        .flush    (flush),
        .push_data({inflight_pc_q, imem_rdata}),
        .head     (head),
        .count    (count)
    );

    assign out_pc     = head[W-1:32];
    assign out_instr  = head[31:0];
    assign out_pc_nxt = out_pc + XLEN'(1);
endmodule
